// File: rtl/os_pe_pkg.sv
// Shared types and constants for the output-stationary PE.
// Holds the FSM state type, default widths and signed saturation limits.
package os_pe_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int ACC_W_DEF = 40;
    // Working width for the limit helpers; callers slice the low bits.
    localparam int LIMIT_W   = 128;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } pe_state_e;

    // Largest positive two's-complement value of width w, in LIMIT_W bits.
    function automatic logic [LIMIT_W-1:0] sat_max(input int w);
        return (LIMIT_W'(1) << (w - 1)) - LIMIT_W'(1);
    endfunction

    // Most negative two's-complement value of width w; its low w bits are 100..0.
    function automatic logic [LIMIT_W-1:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/os_pe_mul.sv
// Registered signed multiplier stage of the PE.
// Kept separate so the product register can be mapped to a DSP block or
// deepened without touching the accumulator/FSM logic.
module os_pe_mul
    import os_pe_pkg::*;
#(
    parameter int IN_W = IN_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IN_W-1:0]   a_i,
    input  logic [IN_W-1:0]   b_i,
    input  logic              en_i,
    output logic [2*IN_W-1:0] p_o,
    output logic              p_valid_o
);

    logic signed [2*IN_W-1:0] prod;
    logic        [2*IN_W-1:0] p_q;
    logic                     p_valid_q;

    // Both operands are sign-extended to the full product width first.
    assign prod = (2*IN_W)'($signed(a_i)) * (2*IN_W)'($signed(b_i));

    // Product register; the valid bit marks whether it must be accumulated.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q       <= '0;
            p_valid_q <= 1'b0;
        end else begin
            p_q       <= prod;
            p_valid_q <= en_i;
        end
    end

    assign p_o       = p_q;
    assign p_valid_o = p_valid_q;

endmodule

// File: rtl/os_pe_pipe.sv
// Output-stationary systolic PE: forwards operands east/south, runs a
// two-stage signed MAC into a local accumulator, and on request flushes the
// result onto a vertical result shift chain.
// Optional feature macro: OS_PE_SAT_EN (saturating accumulation + acc_ovf).
//
// Handshake: operands are taken when in_valid=1 in ACC with op_sel=0; there is
// no backpressure. res_out is qualified by res_out_valid every cycle.
module os_pe_pipe
    import os_pe_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_img,
    input  logic [IN_W-1:0]  in_weight,
    input  logic             in_valid,
    input  logic             op_sel,
    input  logic [ACC_W-1:0] res_in,
    input  logic             res_in_valid,
    output logic [IN_W-1:0]  out_img,
    output logic [IN_W-1:0]  out_weight,
    output logic             out_valid,
    output logic [ACC_W-1:0] res_out,
    output logic             res_out_valid,
    output logic             busy,
    output logic             acc_ovf
);

`ifdef OS_PE_SAT_EN
    localparam logic [LIMIT_W-1:0] MAX_FULL = sat_max(ACC_W);
    localparam logic [LIMIT_W-1:0] MIN_FULL = sat_min(ACC_W);
    localparam logic [ACC_W-1:0]   ACC_MAX  = MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]   ACC_MIN  = MIN_FULL[ACC_W-1:0];
`endif

    pe_state_e         state_q, state_d;
    logic [IN_W-1:0]   out_img_q, out_weight_q;
    logic              out_valid_q;
    logic [ACC_W-1:0]  acc_q;
    logic              acc_ovf_q;
    logic [ACC_W-1:0]  res_out_q;
    logic              res_out_valid_q;

    logic [2*IN_W-1:0] p;
    logic              p_valid;
    logic              mul_en;
    logic [ACC_W-1:0]  p_ext;
    logic [ACC_W:0]    acc_add;    // {overflow, sum}
    logic [ACC_W:0]    flush_add;  // {overflow, sum}

    // Returns {overflow, a+b}; wraps by default, clamps when saturation is built in.
    function automatic logic [ACC_W:0] add_acc(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W-1:0] s;
        logic             ovf;
        s = a + b;
`ifdef OS_PE_SAT_EN
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
        if (ovf) begin
            s = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
`else
        ovf = 1'b0;
`endif
        return {ovf, s};
    endfunction

    // Only operands arriving in ACC without a drain request enter the MAC.
    assign mul_en = in_valid && (state_q == ST_ACC) && !op_sel;

    os_pe_mul #(.IN_W(IN_W)) u_mul (
        .clk_i     (clk),
        .rst_i     (rst),
        .a_i       (in_img),
        .b_i       (in_weight),
        .en_i      (mul_en),
        .p_o       (p),
        .p_valid_o (p_valid)
    );

    // Sign-extend the product and form both candidate sums.
    always_comb begin
        p_ext     = ACC_W'($signed(p));
        acc_add   = add_acc(acc_q, p_ext);
        flush_add = add_acc(acc_q, p_valid ? p_ext : '0);
    end

    // Next-state logic: ACC -> FLUSH on request, FLUSH is a single atomic
    // cycle, DRAIN lasts until the request is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:   if (op_sel) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DRAIN;
            ST_DRAIN: if (!op_sel) state_d = ST_ACC;
            default:  state_d = ST_ACC;
        endcase
    end

    // State, forwarding, accumulator and result-chain registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_ACC;
            out_img_q       <= '0;
            out_weight_q    <= '0;
            out_valid_q     <= 1'b0;
            acc_q           <= '0;
            acc_ovf_q       <= 1'b0;
            res_out_q       <= '0;
            res_out_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_img_q    <= in_img;
            out_weight_q <= in_weight;
            out_valid_q  <= in_valid;
            case (state_q)
                ST_FLUSH: begin
                    // Final add of any in-flight product, then restart clean.
                    res_out_q       <= flush_add[ACC_W-1:0];
                    res_out_valid_q <= 1'b1;
                    acc_q           <= '0;
                    acc_ovf_q       <= flush_add[ACC_W];
                end
                ST_DRAIN: begin
                    res_out_q       <= res_in;
                    res_out_valid_q <= op_sel ? res_in_valid : 1'b0;
                    if (p_valid) begin
                        acc_q     <= acc_add[ACC_W-1:0];
                        acc_ovf_q <= acc_ovf_q | acc_add[ACC_W];
                    end
                end
                default: begin
                    res_out_valid_q <= 1'b0;
                    if (p_valid) begin
                        acc_q     <= acc_add[ACC_W-1:0];
                        acc_ovf_q <= acc_ovf_q | acc_add[ACC_W];
                    end
                end
            endcase
        end
    end

    assign out_img       = out_img_q;
    assign out_weight    = out_weight_q;
    assign out_valid     = out_valid_q;
    assign res_out       = res_out_q;
    assign res_out_valid = res_out_valid_q;
    assign busy          = (state_q != ST_ACC);
    assign acc_ovf       = acc_ovf_q;

endmodule

// File: tb/tb_os_pe_pipe.sv
// Bench for os_pe_pipe: two instances (ACC_W=40 and ACC_W=32) share the
// same stimulus; a queue of accepted products is summed at drain time.
module tb_os_pe_pipe;

    localparam int IN_W = 16;
    localparam int WA   = 40;
    localparam int WB   = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [IN_W-1:0] in_img = '0, in_weight = '0;
    logic            in_valid = 1'b0, op_sel = 1'b0;
    logic [WA-1:0]   res_in_a = '0;
    logic [WB-1:0]   res_in_b = '0;
    logic            res_in_valid = 1'b0;

    logic [IN_W-1:0] out_img_a, out_weight_a, out_img_b, out_weight_b;
    logic            out_valid_a, out_valid_b;
    logic [WA-1:0]   res_out_a;
    logic [WB-1:0]   res_out_b;
    logic            rv_a, rv_b, busy_a, busy_b, ovf_a, ovf_b;

    os_pe_pipe #(.IN_W(IN_W), .ACC_W(WA)) dut_a (
        .clk(clk), .rst(rst), .in_img(in_img), .in_weight(in_weight),
        .in_valid(in_valid), .op_sel(op_sel), .res_in(res_in_a),
        .res_in_valid(res_in_valid), .out_img(out_img_a), .out_weight(out_weight_a),
        .out_valid(out_valid_a), .res_out(res_out_a), .res_out_valid(rv_a),
        .busy(busy_a), .acc_ovf(ovf_a)
    );

    os_pe_pipe #(.IN_W(IN_W), .ACC_W(WB)) dut_b (
        .clk(clk), .rst(rst), .in_img(in_img), .in_weight(in_weight),
        .in_valid(in_valid), .op_sel(op_sel), .res_in(res_in_b),
        .res_in_valid(res_in_valid), .out_img(out_img_b), .out_weight(out_weight_b),
        .out_valid(out_valid_b), .res_out(res_out_b), .res_out_valid(rv_b),
        .busy(busy_b), .acc_ovf(ovf_b)
    );

    // ---------------- scoreboard ----------------
    int     checks = 0;
    int     errors = 0;
    longint prods[$];          // products accepted since the last drain
    logic [WA-1:0] last_a = '0;
    logic [WB-1:0] last_b = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sum of accepted products at width w, wrapping or clamping at each step.
    function automatic void model_sum(input int w, output logic [63:0] res, output logic ovf);
        longint mx, mn, s;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -mx - 1;
        s   = 0;
        ovf = 1'b0;
        foreach (prods[i]) begin
            s = s + prods[i];
`ifdef OS_PE_SAT_EN
            if (s > mx) begin s = mx; ovf = 1'b1; end
            else if (s < mn) begin s = mn; ovf = 1'b1; end
`else
            s = (s <<< (64 - w)) >>> (64 - w);
`endif
        end
        res = 64'(s) & ((64'd1 << w) - 64'd1);
    endfunction

    // ---------------- driver tasks ----------------
    // One clock; outputs are sampled 1 time unit after the edge and the
    // forwarding path is checked against what was driven before the edge.
    task automatic tick();
        logic [IN_W-1:0] pi, pw;
        logic            pv, pr;
        pi = in_img; pw = in_weight; pv = in_valid; pr = rst;
        @(posedge clk);
        #1;
        chk("fwd_img_a",   64'(out_img_a),    pr ? 64'd0 : 64'(pi));
        chk("fwd_wgt_a",   64'(out_weight_a), pr ? 64'd0 : 64'(pw));
        chk("fwd_vld_a",   64'(out_valid_a),  pr ? 64'd0 : 64'(pv));
        chk("fwd_img_b",   64'(out_img_b),    pr ? 64'd0 : 64'(pi));
        chk("fwd_wgt_b",   64'(out_weight_b), pr ? 64'd0 : 64'(pw));
        chk("fwd_vld_b",   64'(out_valid_b),  pr ? 64'd0 : 64'(pv));
    endtask

    task automatic pair(input logic signed [IN_W-1:0] a, input logic signed [IN_W-1:0] b);
        in_img = a; in_weight = b; in_valid = 1'b1; op_sel = 1'b0;
        prods.push_back(longint'(a) * longint'(b));
        tick();
    endtask

    task automatic idle();
        in_img = IN_W'($urandom); in_weight = IN_W'($urandom);
        in_valid = 1'b0; op_sel = 1'b0;
        tick();
    endtask

    // Request a drain carrying (da,db) as operands that must be dropped.
    task automatic drain(input logic [IN_W-1:0] da, input logic [IN_W-1:0] db);
        logic [63:0] ea, eb;
        logic        oa, ob;
        model_sum(WA, ea, oa);
        model_sum(WB, eb, ob);
        in_img = da; in_weight = db; in_valid = 1'b1; op_sel = 1'b1;
        tick();
        chk("flush_busy_a", 64'(busy_a), 64'd1);
        chk("flush_busy_b", 64'(busy_b), 64'd1);
        chk("flush_rv_a",   64'(rv_a),   64'd0);
        chk("pre_ovf_a",    64'(ovf_a),  64'(oa));
        chk("pre_ovf_b",    64'(ovf_b),  64'(ob));
        in_img = IN_W'($urandom); in_weight = IN_W'($urandom);
        in_valid = 1'($urandom); op_sel = 1'($urandom);   // ignored in FLUSH
        tick();
        chk("drain_rv_a",   64'(rv_a),      64'd1);
        chk("drain_rv_b",   64'(rv_b),      64'd1);
        chk("drain_res_a",  64'(res_out_a), ea);
        chk("drain_res_b",  64'(res_out_b), eb);
        chk("drain_busy_a", 64'(busy_a),    64'd1);
        chk("post_ovf_a",   64'(ovf_a),     64'd0);
        chk("post_ovf_b",   64'(ovf_b),     64'd0);
        last_a = WA'(ea); last_b = WB'(eb);
        prods.delete();
    endtask

    task automatic chain(input logic [WB-1:0] w, input logic v);
        op_sel = 1'b1; in_valid = 1'($urandom);
        in_img = IN_W'($urandom); in_weight = IN_W'($urandom);
        res_in_a = WA'(w); res_in_b = w; res_in_valid = v;
        tick();
        chk("chain_res_a", 64'(res_out_a), 64'(w));
        chk("chain_res_b", 64'(res_out_b), 64'(w));
        chk("chain_rv_a",  64'(rv_a),      64'(v));
        chk("chain_rv_b",  64'(rv_b),      64'(v));
        chk("chain_busy",  64'(busy_a),    64'd1);
        last_a = WA'(w); last_b = w;
    endtask

    // Leave DRAIN with valid operands that must not be multiplied.
    task automatic exit_drain();
        op_sel = 1'b0; in_valid = 1'b1;
        in_img = IN_W'($urandom); in_weight = IN_W'($urandom);
        res_in_a = last_a; res_in_b = last_b; res_in_valid = 1'($urandom);
        tick();
        chk("exit_rv_a",   64'(rv_a),   64'd0);
        chk("exit_rv_b",   64'(rv_b),   64'd0);
        chk("exit_busy_a", 64'(busy_a), 64'd0);
        chk("exit_busy_b", 64'(busy_b), 64'd0);
        res_in_a = WA'($urandom); res_in_b = WB'($urandom); res_in_valid = 1'b1;
        idle();
        chk("hold_res_a", 64'(res_out_a), 64'(last_a));
        chk("hold_res_b", 64'(res_out_b), 64'(last_b));
        chk("hold_rv_a",  64'(rv_a),      64'd0);
        res_in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_res_a"},  64'(res_out_a), 64'd0);
        chk({tag, "_res_b"},  64'(res_out_b), 64'd0);
        chk({tag, "_rv_a"},   64'(rv_a),      64'd0);
        chk({tag, "_busy_a"}, 64'(busy_a),    64'd0);
        chk({tag, "_busy_b"}, 64'(busy_b),    64'd0);
        chk({tag, "_ovf_a"},  64'(ovf_a),     64'd0);
        chk({tag, "_ovf_b"},  64'(ovf_b),     64'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        check_reset_state("reset");
        rst = 1'b0;

        // Forwarding in ACC (this pair is also accumulated), then drained
        pair(16'sh1234, 16'sh00FF);
        idle();
        drain(16'h1234, 16'h00FF);
        exit_drain();

        // MAC: (k,k) k=1..10, drain the next cycle -> 385
        for (int k = 1; k <= 10; k++) pair(16'(k), 16'(k));
        drain(16'h0, 16'h0);
        chain(32'd100, 1'b1);
        chain(32'd200, 1'b0);
        chain(32'd300, 1'b1);
        exit_drain();

        // Empty drain: accumulator restarted at zero after the flush
        idle();
        drain(16'h7, 16'h9);
        exit_drain();

        // Pipeline edge: (4,5) arrives with the drain request and is dropped -> 6
        pair(16'sd2, 16'sd3);
        drain(16'sd4, 16'sd5);
        exit_drain();

        // Back-to-back from DRAIN exit: first accepted pair is the one after
        pair(16'sd7, -16'sd3);
        drain(16'h1, 16'h1);
        exit_drain();

        // Overflow: (-32768)^2 three times -> 32-bit instance saturates or wraps
        for (int k = 0; k < 3; k++) pair(16'sh8000, 16'sh8000);
        idle();
        drain(16'h0, 16'h0);
        exit_drain();

        // Randomised rounds
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 14);
            for (int i = 0; i < n; i++) begin
                pair(IN_W'($urandom), IN_W'($urandom));
                if ($urandom_range(0, 3) == 0) idle();
            end
            drain(IN_W'($urandom), IN_W'($urandom));
            for (int c = $urandom_range(0, 3); c > 0; c--) chain(WB'($urandom), 1'($urandom));
            exit_drain();
        end

        // Reset mid-DRAIN while the chain is presenting a valid word
        pair(16'sd5, 16'sd6);
        drain(16'h0, 16'h0);
        chain(32'hABCD, 1'b1);
        rst = 1'b1; in_valid = 1'b1; op_sel = 1'b1;
        tick();
        check_reset_state("mid_rst");
        prods.delete();
        rst = 1'b0; op_sel = 1'b0; in_valid = 1'b0; res_in_valid = 1'b0;
        pair(16'sd3, 16'sd3);
        drain(16'h0, 16'h0);
        exit_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
